// File: rtl/core_mac_pkg.sv
// core_mac_pkg: shared defaults and issue-FSM encoding for the MAC scheduler.
package core_mac_pkg;

    localparam int MAC_NUM_DEF     = 64;
    localparam int IDATA_BIT_DEF   = 8;
    localparam int ACC_BIT_DEF     = 32;
    localparam int LEN_BIT_DEF     = 8;
    localparam int OFIFO_DEPTH_DEF = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    // Occupancy counter width able to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/core_sync_fifo.sv
// core_sync_fifo: first-word fall-through synchronous FIFO, power-of-two depth.
module core_sync_fifo
    import core_mac_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/core_mac_sched.sv
// core_mac_sched: splits dot products into MAC chunks and accumulates returns.
// Define CORE_MAC_SCHED_SAT_EN for a saturating accumulator with sticky ovf.
module core_mac_sched
    import core_mac_pkg::*;
#(
    parameter int MAC_NUM     = MAC_NUM_DEF,
    parameter int IDATA_BIT   = IDATA_BIT_DEF,
    parameter int MAC_OBIT    = IDATA_BIT * 2 + $clog2(MAC_NUM),
    parameter int ACC_BIT     = ACC_BIT_DEF,
    parameter int LEN_BIT     = LEN_BIT_DEF,
    parameter int OFIFO_DEPTH = OFIFO_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LEN_BIT-1:0]           cfg_len,
    input  logic [IDATA_BIT*MAC_NUM-1:0] in_a,
    input  logic [IDATA_BIT*MAC_NUM-1:0] in_b,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [IDATA_BIT*MAC_NUM-1:0] mac_idataA,
    output logic [IDATA_BIT*MAC_NUM-1:0] mac_idataB,
    output logic                         mac_idata_valid,
    input  logic [MAC_OBIT-1:0]          mac_odata,
    input  logic                         mac_odata_valid,
    output logic [ACC_BIT-1:0]           out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         ovf
);

    localparam int CW  = cnt_w(OFIFO_DEPTH);
    localparam int OCW = LEN_BIT + CW;

    logic [0:0]         state;
    logic [LEN_BIT-1:0] remain;
    logic               live;
    logic               fire;
    logic               start;
    logic [LEN_BIT-1:0] len_s;
    logic [CW-1:0]      len_count;
    logic [CW-1:0]      res_count;
    logic [CW-1:0]      credit;
    logic [LEN_BIT-1:0] len_head;
    logic [ACC_BIT-1:0] res_head;
    logic [OCW-1:0]     outstanding;
    logic [LEN_BIT-1:0] rcnt;
    logic [ACC_BIT-1:0] acc;
    logic [ACC_BIT-1:0] ext;
    logic [ACC_BIT-1:0] add_res;
    logic [ACC_BIT-1:0] acc_next;
    logic               ret;
    logic               first;
    logic               last;

    // Started-but-unpushed dot products equal the length-queue occupancy.
    assign credit   = CW'(OFIFO_DEPTH) - res_count - len_count;
    assign in_ready = live && ((state == ST_ISSUE) || (credit != '0));
    assign fire     = in_valid && in_ready;
    assign start    = fire && (state == ST_IDLE);
    assign len_s    = (cfg_len == '0) ? LEN_BIT'(1) : cfg_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live   <= 1'b0;
            state  <= ST_IDLE;
            remain <= '0;
        end else begin
            live <= 1'b1;
            if (start) begin
                if (len_s != LEN_BIT'(1)) begin
                    state  <= ST_ISSUE;
                    remain <= len_s - 1'b1;
                end
            end else if (fire) begin
                remain <= remain - 1'b1;
                if (remain == LEN_BIT'(1))
                    state <= ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_idata_valid <= 1'b0;
            mac_idataA      <= '0;
            mac_idataB      <= '0;
        end else begin
            mac_idata_valid <= fire;
            if (fire) begin
                mac_idataA <= in_a;
                mac_idataB <= in_b;
            end
        end
    end

    // Returns are attributed purely by counting; strays with nothing issued drop.
    assign ret   = mac_odata_valid && (outstanding != '0);
    assign first = (rcnt == '0);
    assign last  = ({1'b0, rcnt} + 1'b1) == {1'b0, len_head};
    assign ext   = ACC_BIT'(mac_odata);

`ifdef CORE_MAC_SCHED_SAT_EN
    logic [ACC_BIT:0] sum_w;
    logic             ovf_q;

    assign sum_w   = {1'b0, acc} + {1'b0, ext};
    assign add_res = sum_w[ACC_BIT] ? '1 : sum_w[ACC_BIT-1:0];
    assign ovf     = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (ret && !first && sum_w[ACC_BIT])
            ovf_q <= 1'b1;
    end
`else
    assign add_res = acc + ext;
    assign ovf     = 1'b0;
`endif

    assign acc_next = first ? ext : add_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            rcnt        <= '0;
            acc         <= '0;
        end else begin
            outstanding <= outstanding + OCW'(mac_idata_valid) - OCW'(ret);
            if (ret) begin
                acc  <= acc_next;
                rcnt <= last ? '0 : rcnt + 1'b1;
            end
        end
    end

    core_sync_fifo #(
        .WIDTH (LEN_BIT),
        .DEPTH (OFIFO_DEPTH)
    ) u_len_q (
        .clk   (clk),
        .rst   (rst),
        .push  (start),
        .din   (len_s),
        .pop   (ret && last),
        .dout  (len_head),
        .count (len_count)
    );

    core_sync_fifo #(
        .WIDTH (ACC_BIT),
        .DEPTH (OFIFO_DEPTH)
    ) u_res_q (
        .clk   (clk),
        .rst   (rst),
        .push  (ret && last),
        .din   (acc_next),
        .pop   (out_valid && out_ready),
        .dout  (res_head),
        .count (res_count)
    );

    assign out_valid = (res_count != '0);
    assign out_data  = out_valid ? res_head : '0;
    assign busy      = (len_count != '0) || (res_count != '0);

endmodule

// File: tb/tb_core_mac_sched.sv
// tb_core_mac_sched: randomized bench with a dot-product scoreboard model.
module tb_core_mac_sched;

    localparam int MAC_NUM     = 64;
    localparam int IDATA_BIT   = 8;
    localparam int ACC_BIT     = 16;
    localparam int LEN_BIT     = 8;
    localparam int OFIFO_DEPTH = 4;
    localparam int MAC_OBIT    = IDATA_BIT * 2 + $clog2(MAC_NUM);
    localparam int VW          = MAC_NUM * IDATA_BIT;
    localparam longint AMAX    = (64'd1 << ACC_BIT) - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [LEN_BIT-1:0]  cfg_len;
    logic [VW-1:0]       in_a;
    logic [VW-1:0]       in_b;
    logic                in_valid;
    logic                in_ready;
    logic [VW-1:0]       mac_idataA;
    logic [VW-1:0]       mac_idataB;
    logic                mac_idata_valid;
    logic [MAC_OBIT-1:0] mac_odata = '0;
    logic                mac_odata_valid = 1'b0;
    logic [ACC_BIT-1:0]  out_data;
    logic                out_valid;
    logic                out_ready;
    logic                busy;
    logic                ovf;

    always #5 clk = ~clk;

    core_mac_sched #(
        .MAC_NUM     (MAC_NUM),
        .IDATA_BIT   (IDATA_BIT),
        .ACC_BIT     (ACC_BIT),
        .LEN_BIT     (LEN_BIT),
        .OFIFO_DEPTH (OFIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_len         (cfg_len),
        .in_a            (in_a),
        .in_b            (in_b),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .mac_idataA      (mac_idataA),
        .mac_idataB      (mac_idataB),
        .mac_idata_valid (mac_idata_valid),
        .mac_odata       (mac_odata),
        .mac_odata_valid (mac_odata_valid),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .busy            (busy),
        .ovf             (ovf)
    );

    int          nvec = 0;
    int          nerr = 0;
    int          npulse = 0;
    longint      last_out = 0;
    longint      expq[$];
    longint      m_acc = 0;
    int          m_rem = 0;
    logic        m_ovf = 1'b0;
    logic [VW-1:0] ca;
    logic [VW-1:0] cb;
    bit          rand_ready = 1'b0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        nvec++;
        if (obs != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint dotp(input logic [VW-1:0] a, input logic [VW-1:0] b);
        longint s = 0;
        for (int i = 0; i < MAC_NUM; i++)
            s += longint'(a[i*IDATA_BIT +: IDATA_BIT]) * longint'(b[i*IDATA_BIT +: IDATA_BIT]);
        return s;
    endfunction

    // MAC line: in-order, random latency, flushed by reset, with stray strobes when idle.
    typedef struct packed {
        longint              t;
        logic [MAC_OBIT-1:0] v;
    } ret_t;
    ret_t   macq[$];
    longint cyc = 0;
    longint last_t = 0;

    always @(posedge clk) begin
        ret_t r;
        #1;
        mac_odata_valid = 1'b0;
        mac_odata = MAC_OBIT'($urandom);
        if (rst) begin
            macq.delete();
            last_t = cyc;
        end else begin
            if (mac_idata_valid) begin
                r.v = MAC_OBIT'(dotp(mac_idataA, mac_idataB));
                r.t = cyc + 1 + longint'($urandom % 4);
                if (r.t <= last_t)
                    r.t = last_t + 1;
                last_t = r.t;
                macq.push_back(r);
            end
            if (macq.size() != 0 && macq[0].t <= cyc) begin
                r = macq.pop_front();
                mac_odata = r.v;
                mac_odata_valid = 1'b1;
            end else if (macq.size() == 0 && ($urandom % 8) == 0) begin
                mac_odata_valid = 1'b1;
            end
        end
        cyc++;
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready)
            out_ready = ($urandom % 4) != 0;
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            npulse++;
            last_out = longint'(out_data);
            chk("out_has_exp", longint'(expq.size() > 0), 1);
            if (expq.size() > 0)
                chk("out_data", longint'(out_data), expq.pop_front());
        end
    end

    task automatic set_uni(input int av, input int bv);
        for (int i = 0; i < MAC_NUM; i++) begin
            ca[i*IDATA_BIT +: IDATA_BIT] = IDATA_BIT'(av);
            cb[i*IDATA_BIT +: IDATA_BIT] = IDATA_BIT'(bv);
        end
    endtask

    task automatic set_one(input int av, input int bv);
        ca = '0;
        cb = '0;
        ca[IDATA_BIT-1:0] = IDATA_BIT'(av);
        cb[IDATA_BIT-1:0] = IDATA_BIT'(bv);
    endtask

    task automatic set_rand(input int maxv);
        for (int i = 0; i < MAC_NUM; i++) begin
            ca[i*IDATA_BIT +: IDATA_BIT] = IDATA_BIT'($urandom_range(maxv, 0));
            cb[i*IDATA_BIT +: IDATA_BIT] = IDATA_BIT'($urandom_range(maxv, 0));
        end
    endtask

    // Call at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send_chunk(input int len);
        int     waited = 0;
        longint s;
        cfg_len = LEN_BIT'(len);
        in_a = ca;
        in_b = cb;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("hs_timeout", longint'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("issue_valid", longint'(mac_idata_valid), 1);
        chk("issue_a", longint'(mac_idataA[63:0]), longint'(ca[63:0]));
        chk("issue_b", longint'(mac_idataB[VW-1:VW-64]), longint'(cb[VW-1:VW-64]));
        s = dotp(ca, cb) & AMAX;
        if (m_rem == 0) begin
            m_rem = (len == 0) ? 1 : len;
            m_acc = s;
        end else begin
            m_acc = m_acc + s;
`ifdef CORE_MAC_SCHED_SAT_EN
            if (m_acc > AMAX) begin
                m_acc = AMAX;
                m_ovf = 1'b1;
            end
`else
            m_acc = m_acc & AMAX;
`endif
        end
        m_rem--;
        if (m_rem == 0)
            expq.push_back(m_acc);
    endtask

    task automatic send_dot(input int len, input int maxv, input bit gaps);
        int n;
        n = (len == 0) ? 1 : len;
        for (int k = 0; k < n; k++) begin
            set_rand(maxv);
            send_chunk(k == 0 ? len : int'($urandom % 256));
            if (gaps && ($urandom % 3) == 0)
                repeat ($urandom_range(2, 1)) @(posedge clk);
            #0;
        end
    endtask

    task automatic drain();
        int w = 0;
        while (expq.size() != 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("drain", longint'(expq.size()), 0);
        @(posedge clk);
        #1;
        chk("idle_busy", longint'(busy), 0);
        chk("ovf", longint'(ovf), longint'(m_ovf));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        expq.delete();
        m_rem = 0;
        m_acc = 0;
        m_ovf = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_ovf", longint'(ovf), 0);
        chk("rst_issue", longint'(mac_idata_valid), 0);
        chk("rst_idata", longint'(mac_idataA[63:0] | mac_idataB[63:0]), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int c0;
        in_valid = 1'b0;
        cfg_len = '0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b1;
        ca = '0;
        cb = '0;
        do_reset();

        // single chunk
        set_uni(2, 3);
        send_chunk(1);
        @(posedge clk);
        #1;
        chk("issue_drop", longint'(mac_idata_valid), 0);
        drain();
        chk("single_sum", last_out, 384);

        // multi-chunk, one result pulse
        c0 = npulse;
        set_one(10, 1);
        send_chunk(3);
        set_one(20, 1);
        send_chunk(0);
        set_one(30, 1);
        send_chunk(0);
        drain();
        chk("multi_pulses", longint'(npulse - c0), 1);
        chk("multi_sum", last_out, 60);

        // backpressure
        c0 = npulse;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_uni(1, k + 1);
            send_chunk(1);
        end
        @(negedge clk);
        chk("bp_in_ready", longint'(in_ready), 0);
        repeat (10) @(negedge clk);
        chk("bp_out_valid", longint'(out_valid), 1);
        chk("bp_no_pop", longint'(npulse - c0), 0);
        @(posedge clk);
        #1;
        fork
            begin
                for (int k = 4; k < 6; k++) begin
                    set_uni(1, k + 1);
                    send_chunk(1);
                end
            end
            begin
                repeat (15) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_pulses", longint'(npulse - c0), 6);
        chk("bp_last", last_out, 384);

        // mixed lengths back to back
        c0 = npulse;
        send_dot(2, 255, 1'b0);
        send_dot(1, 255, 1'b0);
        send_dot(4, 255, 1'b0);
        drain();
        chk("mixed_pulses", longint'(npulse - c0), 3);

        // randomized traffic
        c0 = npulse;
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++)
            send_dot(int'($urandom % 5), 31, 1'b1);
        rand_ready = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("rand_pulses", longint'(npulse - c0), 40);

        // reset mid-operation
        set_rand(31);
        send_chunk(3);
        repeat (2) @(posedge clk);
        do_reset();
        c0 = npulse;
        repeat (20) @(negedge clk);
        chk("rst_no_out", longint'(npulse - c0), 0);
        chk("rst_idle", longint'(busy), 0);
        @(posedge clk);
        #1;
        send_dot(2, 255, 1'b0);
        drain();
        chk("post_rst_pulses", longint'(npulse - c0), 1);

        // accumulator overflow
        do_reset();
        set_uni(255, 4);
        ca[IDATA_BIT-1:0] = IDATA_BIT'(252);
        cb[IDATA_BIT-1:0] = IDATA_BIT'(5);
        send_chunk(2);
        set_one(32, 1);
        send_chunk(0);
        drain();
`ifdef CORE_MAC_SCHED_SAT_EN
        chk("sat_sum", last_out, 64'hFFFF);
        chk("sat_ovf", longint'(ovf), 1);
`else
        chk("wrap_sum", last_out, 64'h0010);
        chk("wrap_ovf", longint'(ovf), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
